// File: rtl/ramio_arbiter.sv
// Two-port arbiter in front of the shared RAM/UART/LED access port.
// Holds one latched command per access, with round-robin ties and a hang timeout.
module ramio_arbiter #(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32,
    parameter int TimeoutCycles   = 4096,
    parameter int TimeoutBitWidth = $clog2(TimeoutCycles + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [AddressBitWidth-1:0] i_address,
    output logic                       i_ack,
    output logic [DataBitWidth-1:0]    i_data,
    input  logic                       d_req,
    input  logic [2:0]                 d_read_type,
    input  logic [1:0]                 d_write_type,
    input  logic [AddressBitWidth-1:0] d_address,
    input  logic [DataBitWidth-1:0]    d_data_in,
    output logic                       d_ack,
    output logic [DataBitWidth-1:0]    d_data,
    output logic                       err,
    output logic                       mem_enable,
    output logic [2:0]                 mem_read_type,
    output logic [1:0]                 mem_write_type,
    output logic [AddressBitWidth-1:0] mem_address,
    output logic [DataBitWidth-1:0]    mem_data_in,
    input  logic [DataBitWidth-1:0]    mem_data_out,
    input  logic                       mem_data_out_ready,
    input  logic                       mem_busy
);

    // state  | meaning
    // IDLE   | no access; mem_* all zero, waiting for a request
    // ACTIVE | latched command driven onto mem_*, waiting for completion or timeout
    // DONE   | ack (and err on abort) high for one cycle; requests ignored
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic                       grant_is_d;
    logic                       last_grant_is_d;
    logic [2:0]                 cmd_read_type;
    logic [1:0]                 cmd_write_type;
    logic [AddressBitWidth-1:0] cmd_address;
    logic [DataBitWidth-1:0]    cmd_data;
    logic [TimeoutBitWidth-1:0] timer;

    logic pick_i;
    logic pick_d;
    logic cmd_is_read;
    logic complete;
    logic timeout_hit;
    logic finish;
    logic [DataBitWidth-1:0] result;

    // Round-robin: on a tie, the port that did not go last wins.
    assign pick_i      = i_req && (!d_req || last_grant_is_d);
    assign pick_d      = d_req && (!i_req || !last_grant_is_d);
    assign cmd_is_read = (cmd_read_type != 3'b000);
    assign complete    = cmd_is_read ? (mem_data_out_ready && !mem_busy) : !mem_busy;
    assign timeout_hit = (timer == TimeoutBitWidth'(TimeoutCycles - 1));
    assign finish      = complete || timeout_hit;
    assign result      = complete ? (cmd_is_read ? mem_data_out : '0) : '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        mem_enable     = 1'b0;
        mem_read_type  = '0;
        mem_write_type = '0;
        mem_address    = '0;
        mem_data_in    = '0;
        case (state)
            IDLE: begin
                if (pick_i || pick_d) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                mem_enable     = 1'b1;
                mem_read_type  = cmd_read_type;
                mem_write_type = cmd_write_type;
                mem_address    = cmd_address;
                mem_data_in    = cmd_data;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_is_d      <= 1'b0;
            last_grant_is_d <= 1'b1;
            cmd_read_type   <= '0;
            cmd_write_type  <= '0;
            cmd_address     <= '0;
            cmd_data        <= '0;
            timer           <= '0;
        end else if (state == IDLE && (pick_i || pick_d)) begin
            grant_is_d      <= pick_d;
            last_grant_is_d <= pick_d;
            timer           <= '0;
            if (pick_d) begin
                cmd_read_type  <= d_read_type;
                cmd_write_type <= d_write_type;
                cmd_address    <= d_address;
                cmd_data       <= d_data_in;
            end else begin
                cmd_read_type  <= 3'b111;
                cmd_write_type <= 2'b00;
                cmd_address    <= i_address;
                cmd_data       <= '0;
            end
        end else if (state == ACTIVE && !finish) begin
            timer <= timer + 1'b1;
        end
    end

    // Completion beats timeout when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            i_data <= '0;
            d_data <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            if (state == ACTIVE && finish) begin
                err <= !complete;
                if (grant_is_d) begin
                    d_ack  <= 1'b1;
                    d_data <= result;
                end else begin
                    i_ack  <= 1'b1;
                    i_data <= result;
                end
            end
        end
    end

endmodule
